capture_controller: RTL and testbench

Acquisition front end directly upstream of the display/sample-buffer stage. Synchronizes raw channel inputs, generates the sample-rate tick, detects the trigger condition and sequences pre-trigger fill, armed and post-trigger capture. Drives the per-channel shift-register buffers with `sample_out` and a one-cycle `shift` strobe, then freezes them (no shifts) while the captured trace is displayed. Replaces the free-running trigger counter in the display stage.

---
 rtl/capture_controller_pkg.sv | 41 ++++
 rtl/capture_controller_input_synchronizer.sv | 35 +++
 rtl/capture_controller.sv | 205 ++++++++++++++++++++
 tb/tb_capture_controller.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_controller_pkg.sv
// Shared definitions for the capture controller: FSM state codes,
// trigger mode codes, default sizing and the trigger predicate.
package capture_controller_pkg;

  // FSM state codes, also exported on the debug 'state' port
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_POST  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Trigger mode codes as driven on 'trig_mode'
  localparam logic [1:0] TRIG_IMMEDIATE = 2'b00;
  localparam logic [1:0] TRIG_RISING    = 2'b01;
  localparam logic [1:0] TRIG_FALLING   = 2'b10;
  localparam logic [1:0] TRIG_ANY       = 2'b11;

  // Default sizing for the full-size acquisition front end
  localparam int DEFAULT_CHANNEL_COUNT    = 10;
  localparam int DEFAULT_SAMPLE_BUFF_SIZE = 640;
  localparam int DEFAULT_PRETRIG_SAMPLES  = 160;
  localparam int DEFAULT_DIV_WIDTH        = 32;

  // Trigger predicate. 'prev' is the last sample shifted into the
  // buffers, 'cur' the sample about to be shifted. An invalid channel
  // select can only fire in immediate mode.
  function automatic logic trigger_hit(input logic [1:0] mode,
                                       input logic       chan_valid,
                                       input logic       prev,
                                       input logic       cur);
    logic hit;
    case (mode)
      TRIG_IMMEDIATE: hit = 1'b1;
      TRIG_RISING:    hit = chan_valid & ~prev & cur;
      TRIG_FALLING:   hit = chan_valid & prev & ~cur;
      default:        hit = chan_valid & (prev ^ cur);
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/capture_controller_input_synchronizer.sv
// Two-flop synchronizer for a bus of independent asynchronous inputs.
// Each bit is synchronized on its own; no cross-bit coherence is implied,
// so this also suits buttons and switches.
module input_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Next-state of the two synchronizer stages
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/capture_controller.sv
// Acquisition front end: synchronizes channel inputs, divides the clock
// down to the sample rate, detects the trigger and sequences the
// pre-trigger fill, armed wait and post-trigger capture. Downstream
// shift-register buffers load 'sample_out' whenever 'shift' is high and
// are left frozen while the controller sits in DONE.
module capture_controller
  import capture_controller_pkg::*;
#(
  parameter int CHANNEL_COUNT    = DEFAULT_CHANNEL_COUNT,
  parameter int SAMPLE_BUFF_SIZE = DEFAULT_SAMPLE_BUFF_SIZE,
  parameter int PRETRIG_SAMPLES  = DEFAULT_PRETRIG_SAMPLES,
  parameter int DIV_WIDTH        = DEFAULT_DIV_WIDTH,
  // Width of trig_chan; may be widened so that selects beyond the last
  // channel can be expressed (they never fire except in immediate mode).
  parameter int TRIG_W           = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNEL_COUNT-1:0] chan_in,
  input  logic [DIV_WIDTH-1:0]     sample_div,
  input  logic [TRIG_W-1:0]        trig_chan,
  input  logic [1:0]               trig_mode,
  input  logic                     arm,
  input  logic                     continuous,
  output logic [CHANNEL_COUNT-1:0] sample_out,
  output logic                     shift,
  output logic [2:0]               state,
  output logic                     triggered,
  output logic                     done
);

  localparam int POST_SAMPLES = SAMPLE_BUFF_SIZE - PRETRIG_SAMPLES;
  localparam int CNT_W        = $clog2(SAMPLE_BUFF_SIZE + 1);

  localparam logic [CNT_W-1:0] PRE_LIMIT  = CNT_W'(PRETRIG_SAMPLES);
  localparam logic [CNT_W-1:0] POST_LIMIT = CNT_W'(POST_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  // Sample counters saturate rather than wrap
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [CHANNEL_COUNT-1:0] sync;

  logic [2:0]               state_q, state_d;
  logic [DIV_WIDTH-1:0]     div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]         fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]         post_cnt_q, post_cnt_d;
  logic [CHANNEL_COUNT-1:0] sample_q, sample_d;
  logic                     shift_q, shift_d;
  logic                     triggered_q, triggered_d;
  logic                     done_q, done_d;

  logic tick_en;
  logic tick;
  logic chan_valid;
  logic prev_bit;
  logic cur_bit;
  logic trig_fire;
  logic start_req;

  input_synchronizer #(
    .WIDTH (CHANNEL_COUNT)
  ) u_input_synchronizer (
    .clk      (clk),
    .reset    (reset),
    .async_in (chan_in),
    .sync_out (sync)
  );

  // Sample-rate tick: the divider only runs in the sampling states. A
  // zero-length fill has nothing to sample, so FILL does not tick then.
  // The >= compare recovers immediately if sample_div drops mid-count.
  always_comb begin
    tick_en = 1'b0;
    case (state_q)
      ST_FILL:           tick_en = (PRETRIG_SAMPLES != 0);
      ST_ARMED, ST_POST: tick_en = 1'b1;
      default:           tick_en = 1'b0;
    endcase
    tick = tick_en && (div_cnt_q >= sample_div);
  end

  // Trigger evaluation: pick the watched channel from the last shifted
  // sample and the incoming synchronized sample. A select beyond the
  // last channel leaves chan_valid low.
  always_comb begin
    chan_valid = 1'b0;
    prev_bit   = 1'b0;
    cur_bit    = 1'b0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      if (trig_chan == TRIG_W'(i)) begin
        chan_valid = 1'b1;
        prev_bit   = sample_q[i];
        cur_bit    = sync[i];
      end
    end
    trig_fire = trigger_hit(trig_mode, chan_valid, prev_bit, cur_bit);
  end

  // Sample register and shift strobe: every tick presents a fresh
  // sample to the buffers for exactly one cycle.
  always_comb begin
    sample_d = tick ? sync : sample_q;
    shift_d  = tick;
  end

  // Capture sequencing: divider, fill/post counters, trigger and done
  // flags. Starting a capture clears everything from the previous one,
  // including the divider phase so the fill starts on a clean period.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;
    done_d      = done_q;
    start_req   = arm | continuous;

    div_cnt_d = div_cnt_q;
    if (tick_en) begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_req) begin
          state_d     = ST_FILL;
          fill_cnt_d  = '0;
          post_cnt_d  = '0;
          triggered_d = 1'b0;
          done_d      = 1'b0;
          div_cnt_d   = '0;
        end
      end
      ST_FILL: begin
        if (PRETRIG_SAMPLES == 0) begin
          state_d = ST_ARMED;
        end else if (tick) begin
          fill_cnt_d = sat_inc(fill_cnt_q);
          if (fill_cnt_d >= PRE_LIMIT) begin
            state_d = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        if (tick && trig_fire) begin
          // The trigger sample itself is the first post-trigger sample
          triggered_d = 1'b1;
          post_cnt_d  = CNT_ONE;
          if (POST_LIMIT <= CNT_ONE) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_POST;
          end
        end
      end
      ST_POST: begin
        if (tick) begin
          post_cnt_d = sat_inc(post_cnt_q);
          if (post_cnt_d >= POST_LIMIT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  // Controller registers; reset aborts any capture in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      sample_q    <= '0;
      shift_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      post_cnt_q  <= post_cnt_d;
      sample_q    <= sample_d;
      shift_q     <= shift_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  assign sample_out = sample_q;
  assign shift      = shift_q;
  assign state      = state_q;
  assign triggered  = triggered_q;
  assign done       = done_q;

endmodule

// File: tb/tb_capture_controller.sv
// Bench for capture_controller with a small 4-channel, 16-deep setup.
// A behavioural model of the capture sequence runs alongside the DUT and
// is compared every cycle; directed scenarios add literal expectations.
module tb_capture_controller;

  localparam int CH   = 4;
  localparam int BUF  = 16;
  localparam int PRE  = 4;
  localparam int POST = BUF - PRE;
  localparam int DW   = 32;
  localparam int TW   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] chan_in;
  logic [DW-1:0] sample_div;
  logic [TW-1:0] trig_chan;
  logic [1:0]    trig_mode;
  logic          arm;
  logic          continuous;
  logic [CH-1:0] sample_out;
  logic          shift;
  logic [2:0]    state;
  logic          triggered;
  logic          done;

  int total = 0;
  int bad   = 0;

  capture_controller #(
    .CHANNEL_COUNT    (CH),
    .SAMPLE_BUFF_SIZE (BUF),
    .PRETRIG_SAMPLES  (PRE),
    .DIV_WIDTH        (DW),
    .TRIG_W           (TW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .chan_in    (chan_in),
    .sample_div (sample_div),
    .trig_chan  (trig_chan),
    .trig_mode  (trig_mode),
    .arm        (arm),
    .continuous (continuous),
    .sample_out (sample_out),
    .shift      (shift),
    .state      (state),
    .triggered  (triggered),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic cont, input logic [DW-1:0] div,
                               input logic [TW-1:0] tch, input logic [1:0] tmode,
                               input logic [CH-1:0] chin);
    arm        = a;
    continuous = cont;
    sample_div = div;
    trig_chan  = tch;
    trig_mode  = tmode;
    chan_in    = chin;
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 pre-trigger fill, 2 waiting for trigger,
  // 3 post-trigger capture, 4 trace frozen.
  logic [CH-1:0] m_delay [2];
  logic [CH-1:0] m_sample;
  bit            m_shift, m_trig, m_done, m_valid = 0;
  int            m_phase, m_since, m_pre, m_post;

  always @(posedge clk) begin
    logic [CH-1:0] incoming;
    bit sampling, take, fire;
    if (reset) begin
      m_delay[0] = '0; m_delay[1] = '0;
      m_sample = '0; m_shift = 0; m_trig = 0; m_done = 0;
      m_phase = 0; m_since = 0; m_pre = 0; m_post = 0;
      m_valid = 1;
    end else begin
      incoming = m_delay[1];
      sampling = (m_phase == 1 && PRE > 0) || m_phase == 2 || m_phase == 3;
      take     = sampling && (m_since >= int'(sample_div));
      fire = 0;
      if (trig_mode == 2'b00) fire = 1;
      else if (int'(trig_chan) < CH) begin
        case (trig_mode)
          2'b01:   fire = !m_sample[trig_chan] && incoming[trig_chan];
          2'b10:   fire = m_sample[trig_chan] && !incoming[trig_chan];
          default: fire = m_sample[trig_chan] != incoming[trig_chan];
        endcase
      end
      if (sampling) m_since = take ? 0 : m_since + 1;
      case (m_phase)
        0, 4: if (arm || continuous) begin
          m_phase = 1; m_since = 0; m_pre = 0; m_post = 0; m_trig = 0;
        end
        1: if (PRE == 0) m_phase = 2;
           else if (take) begin
             m_pre++;
             if (m_pre == PRE) m_phase = 2;
           end
        2: if (take && fire) begin
          m_trig = 1; m_post = 1;
          m_phase = (m_post >= POST) ? 4 : 3;
        end
        3: if (take) begin
          m_post++;
          if (m_post == POST) m_phase = 4;
        end
        default: m_phase = 0;
      endcase
      m_done   = (m_phase == 4);
      m_shift  = take;
      if (take) m_sample = incoming;
      m_delay[1] = m_delay[0];
      m_delay[0] = chan_in;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the clock edge
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("cyc_state",      {29'b0, state},      m_phase);
      checkOutput("cyc_shift",      {31'b0, shift},      {31'b0, m_shift});
      checkOutput("cyc_sample_out", {28'b0, sample_out}, {28'b0, m_sample});
      checkOutput("cyc_triggered",  {31'b0, triggered},  {31'b0, m_trig});
      checkOutput("cyc_done",       {31'b0, done},       {31'b0, m_done});
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int shifts, more, gaps, last, extra, notdone, dn, acc;
    bit seen, tseen, early;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 3'd0, 2'b00, 4'b0000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_state", {29'b0, state}, 0);
    checkOutput("reset_shift", {31'b0, shift}, 0);
    checkOutput("reset_done",  {31'b0, done},  0);

    // Immediate trigger, tick every cycle: 4 fill + 12 post shifts
    $display("[TB] immediate capture");
    applyStimulus(1'b1, 1'b0, 32'd0, 3'd0, 2'b00, 4'b0101);
    @(negedge clk);
    arm = 1'b0;
    shifts = 0; seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (shift) shifts++;
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    checkOutput("imm_done_seen", seen, 1);
    checkOutput("imm_shifts", shifts, 16);
    extra = 0; notdone = 0;
    repeat (10) begin
      @(negedge clk);
      if (shift) extra++;
      if (!done) notdone++;
    end
    checkOutput("imm_frozen_shifts", extra, 0);
    checkOutput("imm_done_held", notdone, 0);
    checkOutput("imm_state_done", {29'b0, state}, 4);

    // Rising edge on channel 2 with a 4-cycle sample period
    $display("[TB] rising trigger");
    applyStimulus(1'b1, 1'b0, 32'd3, 3'd2, 2'b01, 4'b0000);
    @(negedge clk);
    arm = 1'b0;
    gaps = 0; last = -1; more = 0; seen = 0; tseen = 0; early = 0;
    for (int c = 0; c < 400; c++) begin
      if (c == 40) chan_in[2] = 1'b1;
      if (shift) begin
        if (last >= 0 && c - last != 4) gaps++;
        last = c;
      end
      if (triggered && !tseen) begin
        tseen = 1;
        checkOutput("rise_trig_sample_bit2", {31'b0, sample_out[2]}, 1);
        checkOutput("rise_trig_with_shift", {31'b0, shift}, 1);
      end else if (tseen && shift) begin
        more++;
      end else if (!tseen && shift && sample_out[2]) begin
        early = 1;
      end
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    checkOutput("rise_done_seen", seen, 1);
    checkOutput("rise_trig_seen", tseen, 1);
    checkOutput("rise_no_early_bit2", early, 0);
    checkOutput("rise_more_shifts", more, 11);
    checkOutput("rise_gap_errors", gaps, 0);

    // Reset in the middle of post-trigger capture
    $display("[TB] reset mid-capture");
    applyStimulus(1'b1, 1'b0, 32'd3, 3'd0, 2'b00, 4'b1011);
    @(negedge clk);
    arm = 1'b0;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (state == 3'd3) begin seen = 1; break; end
      @(negedge clk);
    end
    checkOutput("rst_reached_post", seen, 1);
    repeat (5) @(negedge clk);
    checkOutput("rst_still_post", {29'b0, state}, 3);
    checkOutput("rst_sample_before", {28'b0, sample_out}, 4'b1011);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_state", {29'b0, state}, 0);
    checkOutput("rst_shift", {31'b0, shift}, 0);
    checkOutput("rst_triggered", {31'b0, triggered}, 0);
    checkOutput("rst_done", {31'b0, done}, 0);
    checkOutput("rst_sample_out", {28'b0, sample_out}, 0);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (shift) extra++;
    end
    checkOutput("rst_no_shift_idle", extra, 0);
    checkOutput("rst_idle_state", {29'b0, state}, 0);

    // Falling trigger on a channel held high never fires
    $display("[TB] falling trigger held off");
    applyStimulus(1'b0, 1'b0, 32'd1, 3'd1, 2'b10, 4'b0010);
    repeat (4) @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    shifts = 0; dn = 0;
    repeat (1000) begin
      @(negedge clk);
      if (shift) shifts++;
      if (done) dn++;
    end
    checkOutput("fall_shifts", shifts, 500);
    checkOutput("fall_done_cycles", dn, 0);
    checkOutput("fall_state_armed", {29'b0, state}, 2);
    checkOutput("fall_sample", {28'b0, sample_out}, 4'b0010);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Continuous re-arm: one DONE cycle then FILL, 16 shifts per capture
    $display("[TB] continuous capture");
    applyStimulus(1'b0, 1'b1, 32'd0, 3'd0, 2'b00, 4'b0110);
    dn = 0; acc = 0;
    for (int c = 0; c < 300 && dn < 3; c++) begin
      @(negedge clk);
      if (shift) acc++;
      if (done) begin
        dn++;
        checkOutput("cont_shifts_per_capture", acc, 16);
        acc = 0;
        @(negedge clk);
        if (shift) acc++;
        checkOutput("cont_done_one_cycle", {31'b0, done}, 0);
        checkOutput("cont_back_to_fill", {29'b0, state}, 1);
      end
    end
    checkOutput("cont_capture_count", dn, 3);
    continuous = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Out-of-range trigger channel in any-edge mode, then immediate
    $display("[TB] out-of-range trigger channel");
    applyStimulus(1'b1, 1'b0, 32'd0, 3'd5, 2'b11, 4'b0000);
    @(negedge clk);
    arm = 1'b0;
    tseen = 0;
    repeat (60) begin
      @(negedge clk);
      chan_in = ~chan_in;
      if (triggered) tseen = 1;
    end
    checkOutput("oor_no_trigger", tseen, 0);
    checkOutput("oor_state_armed", {29'b0, state}, 2);
    trig_mode = 2'b00;
    @(negedge clk);
    checkOutput("oor_imm_triggered", {31'b0, triggered}, 1);
    checkOutput("oor_imm_state_post", {29'b0, state}, 3);
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    checkOutput("oor_done_seen", seen, 1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
